// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for a single fifo, with burst locking of up to BURST_LEN beats.
// Optional macro FIFO_WRITE_ARBITER_COUNT_EN adds a saturating 16-bit accepted-beat counter.
module fifo_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int OWNER_WIDTH = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_LEN   = 4
) (
  input  logic                          in_clock,
  input  logic                          in_reset,
  input  logic [NUM_REQ-1:0]            in_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]            out_grant,
  output logic                          out_put,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          in_full,
  output logic                          out_busy,
  output logic [OWNER_WIDTH-1:0]        out_owner
`ifdef FIFO_WRITE_ARBITER_COUNT_EN
  ,
  output logic [15:0]                   out_beat_count
`endif
);

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e                 state_q, state_d;
  logic [OWNER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [OWNER_WIDTH-1:0] owner_q, owner_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]     grant;
  logic [DATA_WIDTH-1:0]  data_mux;
  logic                   win_found;
  logic [OWNER_WIDTH-1:0] win_idx;
  logic [7:0]             beat_next;

  function automatic logic [OWNER_WIDTH-1:0] wrap_inc(input logic [OWNER_WIDTH-1:0] i);
    return (int'(i) + 1 >= NUM_REQ) ? '0 : OWNER_WIDTH'(int'(i) + 1);
  endfunction

  // Round-robin scan starting at rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && in_req[idx]) begin
        win_found = 1'b1;
        win_idx   = OWNER_WIDTH'(idx);
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches);
  // combinational blocks use blocking '=', the state register below uses non-blocking '<='.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    grant      = '0;
    beat_next  = beat_cnt_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (win_found && !in_full) begin
          grant[win_idx] = 1'b1;
          owner_d        = win_idx;
          if (BURST_LEN == 1) begin
            rr_ptr_d = wrap_inc(win_idx);
          end else begin
            state_d    = S_BURST;
            beat_cnt_d = 8'd1;
          end
        end
      end
      S_BURST: begin
        if (!in_req[owner_q]) begin
          state_d    = S_IDLE;
          rr_ptr_d   = wrap_inc(owner_q);
          beat_cnt_d = 8'd0;
        end else if (!in_full) begin
          grant[owner_q] = 1'b1;
          if (beat_next == 8'(BURST_LEN)) begin
            state_d    = S_IDLE;
            rr_ptr_d   = wrap_inc(owner_q);
            beat_cnt_d = 8'd0;
          end else begin
            beat_cnt_d = beat_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reset wins over any grant, so a burst interrupted by reset transfers no beat.
    if (in_reset) grant = '0;
  end

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) data_mux = data_mux | in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign out_grant = grant;
  assign out_put   = |grant;
  assign out_data  = data_mux;
  assign out_busy  = (state_q == S_BURST);
  assign out_owner = owner_q;

`ifdef FIFO_WRITE_ARBITER_COUNT_EN
  logic [15:0] beat_count_q, beat_count_d;

  always_comb begin
    beat_count_d = beat_count_q;
    if (out_put && beat_count_q != 16'hFFFF) beat_count_d = beat_count_q + 16'd1;
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) beat_count_q <= 16'd0;
    else          beat_count_q <= beat_count_d;
  end

  assign out_beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (BURST_LEN=4 instance plus a BURST_LEN=1 instance).
module tb_fifo_write_arbiter;

  logic        in_clock = 1'b0;
  logic        in_reset = 1'b1;
  logic        in_full  = 1'b0;
  logic [3:0]  req      = '0;
  logic [31:0] data     = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [3:0]  grant;
  logic        put;
  logic [7:0]  odata;
  logic        busy;
  logic [1:0]  owner;

  logic [3:0]  req1  = '0;
  logic [31:0] data1 = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
  logic [3:0]  grant1;
  logic        put1;
  logic [7:0]  odata1;
  logic        busy1;
  logic [1:0]  owner1;

`ifdef FIFO_WRITE_ARBITER_COUNT_EN
  logic [15:0] cnt, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 in_clock = ~in_clock;

  fifo_write_arbiter #(.NUM_REQ(4), .OWNER_WIDTH(2), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .in_clock(in_clock), .in_reset(in_reset), .in_req(req), .in_data(data),
    .out_grant(grant), .out_put(put), .out_data(odata), .in_full(in_full),
    .out_busy(busy), .out_owner(owner)
`ifdef FIFO_WRITE_ARBITER_COUNT_EN
    , .out_beat_count(cnt)
`endif
  );

  fifo_write_arbiter #(.NUM_REQ(4), .OWNER_WIDTH(2), .DATA_WIDTH(8), .BURST_LEN(1)) dut1 (
    .in_clock(in_clock), .in_reset(in_reset), .in_req(req1), .in_data(data1),
    .out_grant(grant1), .out_put(put1), .out_data(odata1), .in_full(in_full),
    .out_busy(busy1), .out_owner(owner1)
`ifdef FIFO_WRITE_ARBITER_COUNT_EN
    , .out_beat_count(cnt1)
`endif
  );

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge in_clock);
    #1;
  endtask

  task automatic apply_reset();
    in_reset = 1'b1;
    in_full  = 1'b0;
    req      = '0;
    req1     = '0;
    step();
    in_reset = 1'b0;
  endtask

  task automatic test_reset();
    in_reset = 1'b1;
    req      = 4'b1111;
    step();
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (put !== 1'b0) begin errors++; $display("FAIL reset_put got %b want 0", put); end
    checks++; if (odata !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", odata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner); end
    req = '0;
    in_reset = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL idle_no_req got %b want 0000", grant); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req = 4'b0001;
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_beat1 got %b want 0001", grant); end
    step();
    checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL mid_beat2 got %b/%b want 0001/1", grant, busy); end
    step();
    in_reset = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000 || put !== 1'b0 || odata !== 8'h00) begin
      errors++; $display("FAIL mid_reset_cycle got %b/%b/%h want 0000/0/00", grant, put, odata); end
    step();
    in_reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || owner !== 2'd0) begin errors++; $display("FAIL post_reset_state got busy %b owner %0d want 0/0", busy, owner); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL post_reset_beat%0d got %b want 0001", c, grant); end
      checks++; if (busy !== (c != 0 && c != 4)) begin errors++; $display("FAIL post_reset_busy%0d got %b want %b", c, busy, (c != 0 && c != 4)); end
      step();
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_own;
    apply_reset();
    req = 4'b1111;
    #1;
    for (int c = 0; c < 20; c++) begin
      exp_own = 2'((c / 4) % 4);
      checks++; if (grant !== (4'b0001 << exp_own)) begin errors++; $display("FAIL rr_grant c%0d got %b want %b", c, grant, 4'b0001 << exp_own); end
      checks++; if (odata !== 8'hA0 + 8'(exp_own)) begin errors++; $display("FAIL rr_data c%0d got %h want %h", c, odata, 8'hA0 + 8'(exp_own)); end
      checks++; if (busy !== (c % 4 != 0)) begin errors++; $display("FAIL rr_busy c%0d got %b want %b", c, busy, (c % 4 != 0)); end
      step();
    end
    req = '0;
  endtask

  task automatic test_early_release();
    apply_reset();
    req = 4'b1010;
    #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL er_beat1 got %b want 0010", grant); end
    step();
    checks++; if (grant !== 4'b0010 || odata !== 8'hA1) begin errors++; $display("FAIL er_beat2 got %b/%h want 0010/a1", grant, odata); end
    step();
    req = 4'b1000;
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL er_release got %b/%b want 0000/1", grant, busy); end
    step();
    checks++; if (grant !== 4'b1000 || odata !== 8'hA3) begin errors++; $display("FAIL er_req3 got %b/%h want 1000/a3", grant, odata); end
    step();
    checks++; if (owner !== 2'd3 || busy !== 1'b1) begin errors++; $display("FAIL er_owner got %0d/%b want 3/1", owner, busy); end
    req = '0;
  endtask

  task automatic test_full_stall();
    apply_reset();
    req     = 4'b0100;
    in_full = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL fs_idle_full got %b/%b want 0000/0", grant, busy); end
    step();
    in_full = 1'b0;
    #1;
    checks++; if (grant !== 4'b0100 || odata !== 8'hA2) begin errors++; $display("FAIL fs_beat1 got %b/%h want 0100/a2", grant, odata); end
    step();
    in_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (put !== 1'b0 || busy !== 1'b1 || owner !== 2'd2) begin
        errors++; $display("FAIL fs_stall%0d got put %b busy %b owner %0d want 0/1/2", c, put, busy, owner); end
      step();
    end
    in_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL fs_resume%0d got %b want 0100", c, grant); end
      step();
    end
    req = '0;
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL fs_done got %b/%b want 0000/0", grant, busy); end
  endtask

  task automatic test_burst_len1();
    logic [3:0] exp_g;
    apply_reset();
    req1 = 4'b0101;
    #1;
    for (int c = 0; c < 4; c++) begin
      exp_g = (c % 2 == 0) ? 4'b0001 : 4'b0100;
      checks++; if (grant1 !== exp_g || busy1 !== 1'b0) begin
        errors++; $display("FAIL bl1_c%0d got %b/%b want %b/0", c, grant1, busy1, exp_g); end
      checks++; if (odata1 !== ((c % 2 == 0) ? 8'hB0 : 8'hB2)) begin
        errors++; $display("FAIL bl1_data_c%0d got %h want %h", c, odata1, (c % 2 == 0) ? 8'hB0 : 8'hB2); end
      step();
    end
    req1 = '0;
  endtask

`ifdef FIFO_WRITE_ARBITER_COUNT_EN
  task automatic test_beat_count();
    apply_reset();
    #1;
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset got %0d want 0", cnt); end
    req = 4'b0001;
    for (int c = 0; c < 10; c++) step();
    req = '0;
    #1;
    checks++; if (cnt !== 16'd10) begin errors++; $display("FAIL cnt_10 got %0d want 10", cnt); end
    force dut.beat_count_q = 16'hFFFE;
    #1;
    release dut.beat_count_q;
    req = 4'b0001;
    for (int c = 0; c < 3; c++) step();
    req = '0;
    #1;
    checks++; if (cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got %h want ffff", cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_round_robin();
    test_early_release();
    test_full_stall();
    test_burst_len1();
`ifdef FIFO_WRITE_ARBITER_COUNT_EN
    test_beat_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Invariants checked on every sampled cycle.
  always @(negedge in_clock) begin
    if (!$onehot0(grant) || (put && in_full) || (put !== |grant)) begin
      errors++;
      $display("FAIL invariant got grant %b put %b full %b want onehot0 and no put while full", grant, put, in_full);
    end
  end

endmodule
